sign_extension: RTL and testbench
=================================

SIGN_EXTENSION -- requirements
Module: sign_extension

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named as the codebase does (I_CLOCK, I_RESET).
REQ-002 Port I_CLOCK  input  1  SHALL be the rising-edge clock.
REQ-003 Port I_RESET  input  1  SHALL be the synchronous active-high reset, sampled on I_CLOCK rising edge.
REQ-004 Port I_Valid  input  1  SHALL qualify In and I_Mode as a conversion request in the current cycle.
REQ-005 Port I_Mode  input  2  SHALL select the conversion: 00 sign-extend; 01 zero-extend; 10 sign-extend then shift left 2; 11 place In in the upper half.
REQ-006 Port In  input  16  SHALL be the raw immediate field, IR[15:0].
REQ-007 Port Out  output  32  SHALL be the converted 32-bit value.
REQ-008 Port O_Valid  output  1  SHALL flag that Out holds a valid conversion result.
REQ-009 Port O_Neg  output  1  SHALL equal Out[31].

Function
REQ-010 Mode 00: Out SHALL be {16{In[15]}, In}.
REQ-011 Mode 01: Out SHALL be {16'h0000, In}.
REQ-012 Mode 10: Out SHALL be {14{In[15]}, In, 2'b00}.
- This is the branch-offset form: word offset to byte offset.
- No overflow is possible in this mode.
REQ-013 Mode 11: Out SHALL be {In, 16'h0000}.
REQ-014 Conversion SHALL be pure bit manipulation; no adders.
REQ-015 When I_Valid is 0:
- Out and O_Neg SHALL hold their previous values in the registered build.
- Out and O_Neg SHALL be don't-care in the combinational build.
- O_Valid SHALL be 0.
REQ-016 Back-to-back requests on consecutive cycles SHALL each produce one result; no bubbles and no backpressure.
REQ-017 O_Neg SHALL be derived from the final Out, so it is 0 for every mode-01 result.

Reset
REQ-018 Registered build: while I_RESET is high at a rising edge, Out SHALL become 32'h0 and O_Neg and O_Valid SHALL become 0.
- I_RESET SHALL take priority over a simultaneous I_Valid.
REQ-019 Combinational build: while I_RESET is high, O_Valid SHALL be forced to 0 combinationally.
REQ-020 A request presented in the same cycle I_RESET is asserted SHALL be dropped; the first result after reset comes from the first request after I_RESET deasserts.

Configuration
REQ-021 Macro SIGNEXT_REG_EN SHALL select the output timing.
REQ-022 With SIGNEXT_REG_EN defined:
- Out, O_Neg and O_Valid SHALL be registered on I_CLOCK rising edge.
- Latency SHALL be 1 cycle from the request edge to the output.
REQ-023 With SIGNEXT_REG_EN undefined:
- Out, O_Neg and O_Valid SHALL be combinational from In, I_Mode and I_Valid.
- Latency SHALL be 0 cycles.
- This build SHALL be usable by the decode stage within the same half-cycle.

Verification
REQ-024 Mode 00, In=16'h8000 -> Out=32'hFFFF8000, O_Neg=1, O_Valid=1.
REQ-025 Mode 00, In=16'h7FFF -> Out=32'h00007FFF, O_Neg=0; Mode 01, In=16'h8000 -> Out=32'h00008000, O_Neg=0.
REQ-026 Mode 10, In=16'hFFFF -> Out=32'hFFFFFFFC, O_Neg=1; Mode 10, In=16'h0001 -> Out=32'h00000004.
REQ-027 Mode 11, In=16'h1234 -> Out=32'h12340000, O_Neg=0; Mode 11, In=16'h8001 -> Out=32'h80010000, O_Neg=1.
REQ-028 Registered build, back-to-back: cycle 0 In=16'h0005, cycle 1 In=16'hFFFE, both mode 00.
- Cycle 1: Out=32'h00000005.
- Cycle 2: Out=32'hFFFFFFFE.
- O_Valid=1 in both cycles.
REQ-029 Registered build, reset mid-stream: I_RESET=1 together with I_Valid=1 and In=16'h8000.
- Next cycle: Out=0, O_Valid=0, O_Neg=0.
- After I_RESET deasserts, the next request's result SHALL appear 1 cycle later.

Source files
------------

// File: rtl/sign_extension.sv
// sign_extension: turns a 16-bit immediate field into a 32-bit operand
// (sign-extend, zero-extend, branch byte offset, or upper-half placement).
// Latency: 0 cycles by default; 1 cycle when SIGNEXT_REG_EN is defined.
// No backpressure: a result is produced for every request, back-to-back.
//
// Build option: define SIGNEXT_REG_EN to register Out/O_Neg/O_Valid on
// I_CLOCK. Leave it undefined for the combinational (decode-stage) form.
//
// Ports:
//   I_CLOCK  in   1  rising-edge clock (used only by the registered build)
//   I_RESET  in   1  synchronous active-high reset
//   I_Valid  in   1  qualifies In/I_Mode as a conversion request
//   I_Mode   in   2  00 sext, 01 zext, 10 sext<<2, 11 In in upper half
//   In       in  16  raw immediate field IR[15:0]
//   Out      out 32  converted value
//   O_Valid  out  1  Out holds a valid result
//   O_Neg    out  1  copy of Out[31]

module sign_extension (
    input  logic        I_CLOCK,
    input  logic        I_RESET,
    input  logic        I_Valid,
    input  logic [1:0]  I_Mode,
    input  logic [15:0] In,
    output logic [31:0] Out,
    output logic        O_Valid,
    output logic        O_Neg
);

    typedef enum logic [1:0] {
        MODE_SEXT   = 2'b00,
        MODE_ZEXT   = 2'b01,
        MODE_BRANCH = 2'b10,
        MODE_UPPER  = 2'b11
    } mode_e;

    // Pure wiring/replication: no arithmetic is needed for any mode, and the
    // branch form cannot overflow since the two bits shifted out are copies
    // of the sign bit.
    logic [31:0] conv_d;

    always_comb begin
        conv_d = 32'h0000_0000;
        case (mode_e'(I_Mode))
            MODE_SEXT:   conv_d = {{16{In[15]}}, In};
            MODE_ZEXT:   conv_d = {16'h0000, In};
            MODE_BRANCH: conv_d = {{14{In[15]}}, In, 2'b00};
            MODE_UPPER:  conv_d = {In, 16'h0000};
            default:     conv_d = 32'h0000_0000;
        endcase
    end

`ifdef SIGNEXT_REG_EN

    logic [31:0] out_q;
    logic        neg_q;
    logic        vld_q;

    // Reset wins over a simultaneous request, so that request is dropped.
    // Out/O_Neg hold their last value on idle cycles.
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            out_q <= 32'h0000_0000;
            neg_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= I_Valid;
            if (I_Valid) begin
                out_q <= conv_d;
                neg_q <= conv_d[31];
            end
        end
    end

    assign Out     = out_q;
    assign O_Neg   = neg_q;
    assign O_Valid = vld_q;

`else

    // Clock is not needed in this build.
    logic unused_clk;
    assign unused_clk = I_CLOCK;

    // Out/O_Neg are only meaningful when O_Valid is high; reset merely
    // suppresses the valid flag.
    assign Out     = conv_d;
    assign O_Neg   = conv_d[31];
    assign O_Valid = I_Valid & ~I_RESET;

`endif

endmodule

// File: tb/tb_sign_extension.sv
// Self-checking bench for sign_extension, for either build
// (SIGNEXT_REG_EN defined: 1-cycle latency; undefined: combinational).
// An arithmetic model is compared every cycle; literal pins anchor it.

module tb_sign_extension;

`ifdef SIGNEXT_REG_EN
    localparam int  LAT = 1;
    localparam bit  REG_BUILD = 1'b1;
`else
    localparam int  LAT = 0;
    localparam bit  REG_BUILD = 1'b0;
`endif

    logic        I_CLOCK = 1'b0;
    logic        I_RESET = 1'b1;
    logic        I_Valid = 1'b0;
    logic [1:0]  I_Mode  = 2'b00;
    logic [15:0] In      = 16'h0000;
    logic [31:0] Out;
    logic        O_Valid;
    logic        O_Neg;

    sign_extension dut (
        .I_CLOCK (I_CLOCK),
        .I_RESET (I_RESET),
        .I_Valid (I_Valid),
        .I_Mode  (I_Mode),
        .In      (In),
        .Out     (Out),
        .O_Valid (O_Valid),
        .O_Neg   (O_Neg)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic view of each mode.
    function automatic logic [31:0] conv(input logic [1:0] m, input logic [15:0] d);
        longint s;
        longint u;
        longint r;
        s = longint'($signed(d));
        u = longint'(d);
        case (m)
            2'd0:    r = s;
            2'd1:    r = u;
            2'd2:    r = s * 4;
            default: r = u * 65536;
        endcase
        return r[31:0];
    endfunction

    function automatic logic is_neg(input logic [31:0] v);
        return $signed(v) < 0;
    endfunction

    // Cycle counter and registered-build model, updated on the clock edge.
    int          cyc = 0;
    logic        chk_en = 1'b0;
    logic [31:0] m_out = 32'h0;
    logic        m_vld = 1'b0;

    always @(posedge I_CLOCK) begin
        cyc = cyc + 1;
        if (I_RESET) begin
            m_out  = 32'h0;
            m_vld  = 1'b0;
            chk_en = 1'b1;
        end else if (I_Valid) begin
            m_out = conv(I_Mode, In);
            m_vld = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
    end

    // Literal expectations, keyed by the cycle in which they must be seen.
    logic        pin_en  [512];
    logic        pin_vld [512];
    logic        pin_oen [512];
    logic [31:0] pin_out [512];
    logic        pin_neg [512];

    initial begin
        for (int i = 0; i < 512; i++) pin_en[i] = 1'b0;
    end

    // Compare process: mid-cycle, inputs and outputs settled.
    always @(negedge I_CLOCK) begin
        int k;
        logic [31:0] e_out;
        logic        e_vld;
        if (chk_en) begin
            if (REG_BUILD) begin
                e_vld = m_vld;
                e_out = m_out;
            end else begin
                e_vld = I_Valid && !I_RESET;
                e_out = conv(I_Mode, In);
            end
            check("model_valid", {31'b0, O_Valid}, {31'b0, e_vld});
            if (REG_BUILD || e_vld) begin
                check("model_out", Out, e_out);
                check("model_neg", {31'b0, O_Neg}, {31'b0, is_neg(e_out)});
            end
        end
        k = cyc % 512;
        if (pin_en[k]) begin
            pin_en[k] = 1'b0;
            check("pin_valid", {31'b0, O_Valid}, {31'b0, pin_vld[k]});
            if (pin_oen[k]) begin
                check("pin_out", Out, pin_out[k]);
                check("pin_neg", {31'b0, O_Neg}, {31'b0, pin_neg[k]});
            end
        end
    end

    // One call = one cycle of stimulus, optionally with a literal expectation
    // for the cycle in which that request's result must appear.
    task automatic drive(input logic rst, input logic vld, input logic [1:0] mode,
                         input logic [15:0] din, input logic pin, input logic pv,
                         input logic poen, input logic [31:0] pout, input logic pneg);
        int k;
        @(posedge I_CLOCK);
        #1;
        I_RESET = rst;
        I_Valid = vld;
        I_Mode  = mode;
        In      = din;
        if (pin) begin
            k = (cyc + LAT) % 512;
            pin_en[k]  = 1'b1;
            pin_vld[k] = pv;
            pin_oen[k] = poen;
            pin_out[k] = pout;
            pin_neg[k] = pneg;
        end
    endtask

    logic [15:0] vals [8] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000,
                              16'hFFFF, 16'h00FF, 16'hA5A5, 16'h4000};

    initial begin
        // Reset with no request; registered outputs must clear.
        drive(1, 0, 2'd0, 16'h0000, 0, 0, 0, 32'h0, 0);
        drive(1, 0, 2'd0, 16'h0000, 1, 0, REG_BUILD, 32'h0, 0);

        // Hand-computed vectors.
        drive(0, 1, 2'd0, 16'h8000, 1, 1, 1, 32'hFFFF8000, 1);
        drive(0, 1, 2'd0, 16'h7FFF, 1, 1, 1, 32'h00007FFF, 0);
        drive(0, 1, 2'd1, 16'h8000, 1, 1, 1, 32'h00008000, 0);
        drive(0, 1, 2'd2, 16'hFFFF, 1, 1, 1, 32'hFFFFFFFC, 1);
        drive(0, 1, 2'd2, 16'h0001, 1, 1, 1, 32'h00000004, 0);
        drive(0, 1, 2'd3, 16'h1234, 1, 1, 1, 32'h12340000, 0);
        drive(0, 1, 2'd3, 16'h8001, 1, 1, 1, 32'h80010000, 1);
        drive(0, 1, 2'd1, 16'hFFFF, 1, 1, 1, 32'h0000FFFF, 0);

        // Back-to-back, then an idle cycle: registered Out holds, valid drops.
        drive(0, 1, 2'd0, 16'h0005, 1, 1, 1, 32'h00000005, 0);
        drive(0, 1, 2'd0, 16'hFFFE, 1, 1, 1, 32'hFFFFFFFE, 1);
        drive(0, 0, 2'd1, 16'h0003, 1, 0, REG_BUILD, 32'hFFFFFFFE, 1);

        // Reset mid-stream, colliding with a request that must be dropped.
        drive(0, 1, 2'd3, 16'h1234, 1, 1, 1, 32'h12340000, 0);
        drive(1, 1, 2'd0, 16'h8000, 1, 0, REG_BUILD, 32'h0, 0);
        drive(0, 1, 2'd1, 16'h8000, 1, 1, 1, 32'h00008000, 0);
        drive(0, 0, 2'd0, 16'h0000, 0, 0, 0, 32'h0, 0);

        // Every mode over a table of edge values, with occasional idles;
        // the model check covers these.
        for (int m = 0; m < 4; m++) begin
            for (int v = 0; v < 8; v++) begin
                drive(0, 1'b1, 2'(m), vals[v], 0, 0, 0, 32'h0, 0);
                if (v == 3) drive(0, 0, 2'(m), 16'hDEAD, 0, 0, 0, 32'h0, 0);
            end
        end

        drive(0, 0, 2'd0, 16'h0000, 0, 0, 0, 32'h0, 0);
        drive(0, 0, 2'd0, 16'h0000, 0, 0, 0, 32'h0, 0);
        @(posedge I_CLOCK);
        @(posedge I_CLOCK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
